// File: rtl/sram_avmm_ctrl.sv
// Avalon-MM slave to asynchronous SRAM bridge. Each accepted single-word read or
// write becomes one SRAM cycle with configurable read wait, write setup, write
// pulse and read-to-write bus turnaround.
module sram_avmm_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned WR_SETUP   = 1,
    parameter int unsigned WR_PULSE   = 2,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic                avs_waitrequest,
    output logic [ADDR_W-1:0]   sram_addr,
    inout  wire  [DATA_W-1:0]   sram_dq,
    output logic [DATA_W/8-1:0] sram_ben,
    output logic                sram_cen,
    output logic                sram_oen,
    output logic                sram_wen
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned PH_MAX0 = (RD_WAIT > WR_SETUP) ? RD_WAIT : WR_SETUP;
    localparam int unsigned PH_MAX  = (PH_MAX0 > WR_PULSE) ? PH_MAX0 : WR_PULSE;
    localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
    localparam int unsigned TA_W    = $clog2(TURNAROUND + 2);

    localparam logic [PH_W-1:0] RD_LAST = PH_W'(RD_WAIT - 1);
    localparam logic [PH_W-1:0] SU_LAST = PH_W'(WR_SETUP - 1);
    localparam logic [PH_W-1:0] WP_LAST = PH_W'(WR_PULSE - 1);
    localparam logic [TA_W-1:0] TA_INIT = TA_W'(TURNAROUND);

    typedef enum logic [2:0] {StIdle, StRd, StWrSu, StWrP, StWrH} state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [TA_W-1:0]   ta_q, ta_d;
    logic              rvalid_q;
    logic              ld_req, ld_rdata;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [BE_W-1:0]   be_q;
    logic              idle_rdy, wr_phase, be_any;

    assign idle_rdy = (state_q == StIdle) && (ta_q == '0);

    // FSM, phase counter, turnaround counter and readdatavalid pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ph_q     <= '0;
            ta_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            ta_q     <= ta_d;
            rvalid_q <= ld_rdata;
        end
    end

    // Request latch on acceptance, read data capture on the last RD cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (ld_req) begin
                addr_q  <= avs_address;
                wdata_q <= avs_writedata;
                be_q    <= avs_byteenable;
            end
            if (ld_rdata) begin
                rdata_q <= sram_dq;
            end
        end
    end

    // Next-state logic; write wins when read and write arrive together
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        ta_d     = ta_q;
        ld_req   = 1'b0;
        ld_rdata = 1'b0;
        unique case (state_q)
            StIdle: begin
                ph_d = '0;
                if (ta_q != '0) begin
                    ta_d = ta_q - TA_W'(1);
                end else if (avs_write) begin
                    state_d = StWrSu;
                    ld_req  = 1'b1;
                end else if (avs_read) begin
                    state_d = StRd;
                    ld_req  = 1'b1;
                end
            end
            StRd: begin
                if (ph_q == RD_LAST) begin
                    state_d  = StIdle;
                    ph_d     = '0;
                    ta_d     = TA_INIT;
                    ld_rdata = 1'b1;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            StWrSu: begin
                if (ph_q == SU_LAST) begin
                    state_d = StWrP;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            StWrP: begin
                if (ph_q == WP_LAST) begin
                    state_d = StWrH;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            StWrH: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                ph_d    = '0;
            end
        endcase
    end

    // SRAM strobes decoded from state so an async reset releases them at once;
    // a write with no byte lanes keeps the chip deselected
    always_comb begin
        wr_phase        = (state_q == StWrSu) || (state_q == StWrP) || (state_q == StWrH);
        be_any          = |be_q;
        sram_cen        = !((state_q == StRd) || (wr_phase && be_any));
        sram_oen        = !(state_q == StRd);
        sram_wen        = !((state_q == StWrP) && be_any);
        sram_ben        = (state_q == StIdle) ? {BE_W{1'b1}} : ~be_q;
        avs_waitrequest = !idle_rdy;
    end

    assign sram_dq           = wr_phase ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr         = addr_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sram_avmm_ctrl.sv
// Bench for sram_avmm_ctrl: a default 16-bit instance driven from a vector table
// plus hand sequences, and a 32-bit RD_WAIT=1 TURNAROUND=0 instance.
module tb_sram_avmm_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit default instance
    logic [20:0] a_addr = '0;
    logic        a_read = 1'b0, a_write = 1'b0;
    logic [15:0] a_wdata = '0;
    logic [1:0]  a_be = '0;
    logic [15:0] a_rdata;
    logic        a_rv, a_wait, a_cen, a_oen, a_wen;
    logic [20:0] a_saddr;
    logic [1:0]  a_ben;
    tri1  [15:0] a_dq;

    sram_avmm_ctrl dut_a (
        .clk(clk), .reset_n(rst_n),
        .avs_address(a_addr), .avs_read(a_read), .avs_write(a_write),
        .avs_writedata(a_wdata), .avs_byteenable(a_be),
        .avs_readdata(a_rdata), .avs_readdatavalid(a_rv), .avs_waitrequest(a_wait),
        .sram_addr(a_saddr), .sram_dq(a_dq), .sram_ben(a_ben),
        .sram_cen(a_cen), .sram_oen(a_oen), .sram_wen(a_wen)
    );

    // 32-bit instance, single-cycle read wait, no turnaround
    logic [20:0] b_addr = '0;
    logic        b_read = 1'b0, b_write = 1'b0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_be = '0;
    logic [31:0] b_rdata;
    logic        b_rv, b_wait, b_cen, b_oen, b_wen;
    logic [20:0] b_saddr;
    logic [3:0]  b_ben;
    tri1  [31:0] b_dq;

    sram_avmm_ctrl #(.DATA_W(32), .ADDR_W(21), .RD_WAIT(1), .WR_SETUP(1), .WR_PULSE(2),
                     .TURNAROUND(0)) dut_b (
        .clk(clk), .reset_n(rst_n),
        .avs_address(b_addr), .avs_read(b_read), .avs_write(b_write),
        .avs_writedata(b_wdata), .avs_byteenable(b_be),
        .avs_readdata(b_rdata), .avs_readdatavalid(b_rv), .avs_waitrequest(b_wait),
        .sram_addr(b_saddr), .sram_dq(b_dq), .sram_ben(b_ben),
        .sram_cen(b_cen), .sram_oen(b_oen), .sram_wen(b_wen)
    );

    // SRAM models: drive data while selected for read, store enabled lanes while wen low
    logic [15:0] mem_a [0:255];
    logic [31:0] mem_b [0:15];
    assign a_dq = (!a_cen && !a_oen && a_wen) ? mem_a[a_saddr[7:0]] : 'z;
    assign b_dq = (!b_cen && !b_oen && b_wen) ? mem_b[b_saddr[3:0]] : 'z;

    always @(negedge clk) begin
        if (!a_cen && !a_wen)
            for (int k = 0; k < 2; k++)
                if (!a_ben[k]) mem_a[a_saddr[7:0]][8*k +: 8] <= a_dq[8*k +: 8];
        if (!b_cen && !b_wen)
            for (int k = 0; k < 4; k++)
                if (!b_ben[k]) mem_b[b_saddr[3:0]][8*k +: 8] <= b_dq[8*k +: 8];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-data scoreboards
    logic [15:0] exp_qa[$];
    logic [31:0] exp_qb[$];
    int rv_cnt_a = 0, rv_cyc_a = 0, rv_cyc_b = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rv) begin
                rv_cnt_a++;
                rv_cyc_a = cyc;
                if (exp_qa.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_unexpected_a: got readdatavalid with %0h", a_rdata);
                end else check("rd_data_a", a_rdata, exp_qa.pop_front());
            end
            if (b_rv) begin
                rv_cyc_b = cyc;
                if (exp_qb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_unexpected_b: got readdatavalid with %0h", b_rdata);
                end else check("rd_data_b", b_rdata, exp_qb.pop_front());
            end
            if (!a_oen) check("oen_low_with_wen_low", a_wen, 1'b1);
        end
    end

    typedef struct {
        logic        wr;
        logic [20:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [15:0] exp_rd;
        int          exp_wait;  // waitrequest-high cycles after accept
        int          exp_wen;   // wen-low cycles
        int          exp_oen;   // oen-low cycles
        int          exp_cen;   // cen-low cycles
        logic [1:0]  exp_ben;   // ben seen while strobing
    } vec_t;

    task automatic do_req(input vec_t v);
        int t, acc, nw, nwen, noen, ncen;
        logic [1:0]  ben_s;
        logic [15:0] dq_s;
        @(negedge clk);
        a_addr = v.addr; a_wdata = v.data; a_be = v.be;
        a_write = v.wr; a_read = !v.wr;
        if (!v.wr) exp_qa.push_back(v.exp_rd);
        t = 0;
        while (a_wait && t < 40) begin @(negedge clk); t++; end
        check("accept_wait", a_wait, 1'b0);
        @(posedge clk);
        @(negedge clk);
        a_read = 1'b0; a_write = 1'b0; acc = cyc;
        nw = 0; nwen = 0; noen = 0; ncen = 0; ben_s = '1; dq_s = '0;
        for (int i = 0; i < 40; i++) begin
            if (!a_wen) begin nwen++; ben_s = a_ben; dq_s = a_dq; end
            if (!a_oen) begin noen++; ben_s = a_ben; end
            if (!a_cen) ncen++;
            if (!a_wait) break;
            nw++;
            @(negedge clk);
        end
        #1;
        check("busy_cycles", nw, v.exp_wait);
        check("wen_low_cycles", nwen, v.exp_wen);
        check("oen_low_cycles", noen, v.exp_oen);
        check("cen_low_cycles", ncen, v.exp_cen);
        check("ben", ben_s, v.exp_ben);
        if (v.wr && v.be != 2'b00) check("wr_dq", dq_s, v.data);
        // readdatavalid sampled by the master RD_WAIT+1 edges after accept
        if (!v.wr) check("rd_latency", rv_cyc_a - acc + 1, 3);
    endtask

    task automatic b_req(input logic wr, input logic [20:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output int acc);
        int t;
        @(negedge clk);
        b_addr = addr; b_wdata = data; b_be = be; b_write = wr; b_read = !wr;
        t = 0;
        while (b_wait && t < 40) begin @(negedge clk); t++; end
        check("b_accept_wait", b_wait, 1'b0);
        @(posedge clk);
        @(negedge clk);
        b_read = 1'b0; b_write = 1'b0; acc = cyc;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 40 && a_wait; i++) @(negedge clk);
        check("idle_a", a_wait, 1'b0);
    endtask

    vec_t vecs[8];
    vec_t vfin;

    initial begin
        int acc, nw, rv0, acc2;
        logic saw_wen, saw_oen;

        vecs[0] = '{1'b1, 21'h10, 16'hA55A, 2'b11, 16'h0000, 4, 2, 0, 4, 2'b00};
        vecs[1] = '{1'b0, 21'h10, 16'h0000, 2'b11, 16'hA55A, 3, 0, 2, 2, 2'b00};
        vecs[2] = '{1'b1, 21'h10, 16'h1234, 2'b01, 16'h0000, 4, 2, 0, 4, 2'b10};
        vecs[3] = '{1'b0, 21'h10, 16'h0000, 2'b11, 16'hA534, 3, 0, 2, 2, 2'b00};
        vecs[4] = '{1'b1, 21'h20, 16'hBEEF, 2'b00, 16'h0000, 4, 0, 0, 0, 2'b11};
        vecs[5] = '{1'b0, 21'h20, 16'h0000, 2'b11, 16'hC3C3, 3, 0, 2, 2, 2'b00};
        vecs[6] = '{1'b1, 21'h31, 16'hFFFF, 2'b10, 16'h0000, 4, 2, 0, 4, 2'b01};
        vecs[7] = '{1'b0, 21'h31, 16'h0000, 2'b11, 16'hFFC3, 3, 0, 2, 2, 2'b00};
        vfin    = '{1'b0, 21'h40, 16'h0000, 2'b11, 16'h0F0F, 3, 0, 2, 2, 2'b00};
        for (int i = 0; i < 256; i++) mem_a[i] <= 16'hC3C3;
        for (int i = 0; i < 16; i++) mem_b[i] <= 32'h0;

        // Reset state
        #3;
        check("rst_strobes", {a_cen, a_oen, a_wen, a_ben}, 5'b11111);
        check("rst_addr", a_saddr, 21'h0);
        check("rst_rdata", {a_rdata, a_rv}, 17'h0);
        check("rst_dq_released", a_dq, 16'hFFFF);
        check("rst_waitrequest", a_wait, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) do_req(vecs[i]);

        // Read followed by a held write: one turnaround cycle with the bus released
        @(negedge clk);
        a_addr = 21'h10; a_be = 2'b11; a_read = 1'b1;
        exp_qa.push_back(16'hA534);
        for (int i = 0; i < 40 && a_wait; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        a_read = 1'b0; a_write = 1'b1; a_addr = 21'h40; a_wdata = 16'h0F0F;
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            if (!a_wait) break;
            if (cyc == acc + 2) begin
                check("ta_oen", a_oen, 1'b1);
                check("ta_dq_released", a_dq, 16'hFFFF);
            end
            nw++;
            @(negedge clk);
        end
        check("rd_then_wr_busy", nw, 3);
        @(posedge clk);
        @(negedge clk);
        a_write = 1'b0;
        wait_idle_a();
        do_req(vfin);

        // Read and write together: write first, read stays pending and sees new data
        @(negedge clk);
        rv0 = rv_cnt_a;
        a_addr = 21'h50; a_wdata = 16'h6789; a_be = 2'b11; a_read = 1'b1; a_write = 1'b1;
        exp_qa.push_back(16'h6789);
        for (int i = 0; i < 40 && a_wait; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        a_write = 1'b0;
        saw_wen = 1'b0; saw_oen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!a_wen) saw_wen = 1'b1;
            if (!a_oen) saw_oen = 1'b1;
            if (!a_wait) break;
            @(negedge clk);
        end
        check("both_write_first", {saw_wen, saw_oen}, 2'b10);
        @(posedge clk);
        @(negedge clk);
        a_read = 1'b0;
        repeat (6) @(negedge clk);
        check("both_rv_once", rv_cnt_a - rv0, 1);

        // Async reset during the write pulse
        @(negedge clk);
        a_addr = 21'h60; a_wdata = 16'h1111; a_be = 2'b11; a_write = 1'b1;
        for (int i = 0; i < 40 && a_wait; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        a_write = 1'b0;
        @(negedge clk);
        check("pre_rst_wen", a_wen, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {a_cen, a_oen, a_wen}, 3'b111);
        check("rst_mid_dq", a_dq, 16'hFFFF);
        @(negedge clk);
        check("rst_mid_rv", a_rv, 1'b0);
        rst_n = 1'b1;

        // 32-bit instance: lanes, 2-cycle latency, no turnaround between reads
        b_req(1'b1, 21'h3, 32'h11223344, 4'hF, acc);
        for (int i = 0; i < 40 && b_wait; i++) @(negedge clk);
        b_req(1'b1, 21'h3, 32'hAABBCCDD, 4'b0101, acc);
        @(negedge clk);
        check("b_wr_strobes", {b_cen, b_oen, b_wen}, 3'b010);
        check("b_wr_ben", b_ben, 4'b1010);
        check("b_wr_dq", b_dq, 32'hAABBCCDD);
        for (int i = 0; i < 40 && b_wait; i++) @(negedge clk);
        exp_qb.push_back(32'h11BB33DD);
        exp_qb.push_back(32'h11BB33DD);
        b_req(1'b0, 21'h3, 32'h0, 4'hF, acc);
        b_req(1'b0, 21'h3, 32'h0, 4'hF, acc2);
        check("b_rd_latency", rv_cyc_b - acc + 1, 2);
        check("b_rd_throughput", acc2 - acc, 2);
        repeat (5) @(negedge clk);

        check("scoreboard_a_empty", exp_qa.size(), 0);
        check("scoreboard_b_empty", exp_qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

endmodule
